// File: rtl/mips_alu_pkg.sv
// Shared definitions for the MIPS-Lite execute-stage iterative units (divider, multiplier):
// sequencer states, iteration count and the HI/LO field positions of the 64-bit result.
package mips_alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    localparam int DIV_ITER = 32;

    // HI holds the remainder (divider) or upper product half (multiplier); LO the quotient/lower half.
    localparam int HI_MSB = 63;
    localparam int HI_LSB = 32;
    localparam int LO_MSB = 31;
    localparam int LO_LSB = 0;

endpackage

// File: rtl/divider_if.sv
// Start/result bundle between the execute stage and the divider.
// With DIVIDER_SIGNED_EN defined the bundle also carries the sgn operand-mode bit.
interface divider_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic               sel;
`ifdef DIVIDER_SIGNED_EN
    logic               sgn;
`endif
    logic [2*WIDTH-1:0] DIVUAns;
    logic               busy;
    logic               done;
    logic               div_by_zero;

`ifdef DIVIDER_SIGNED_EN
    modport master (output A, B, sel, sgn, input DIVUAns, busy, done, div_by_zero);
    modport slave  (input A, B, sel, sgn, output DIVUAns, busy, done, div_by_zero);
`else
    modport master (output A, B, sel, input DIVUAns, busy, done, div_by_zero);
    modport slave  (input A, B, sel, output DIVUAns, busy, done, div_by_zero);
`endif

endinterface

// File: rtl/divider_step.sv
// One restoring-division iteration: shift {rem, quot} left, trial-subtract the divisor,
// keep the difference and set the quotient bit if it did not go negative.
module divider_step
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = DIV_ITER
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quot_o
);

    logic [2*WIDTH:0] shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        shifted = {rem_i, quot_i} << 1;
        // The partial remainder stays below the divisor, so WIDTH+1 bits never overflow.
        trial   = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_i};
        if (!trial[WIDTH]) begin
            rem_o  = trial;
            quot_o = {shifted[WIDTH-1:1], 1'b1};
        end else begin
            rem_o  = shifted[2*WIDTH:WIDTH];
            quot_o = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/divider.sv
// Sequential restoring divider (DIVU): one quotient bit per clock, {remainder, quotient} on done.
// Optional DIVIDER_SIGNED_EN adds signed operation via magnitude conversion around the same core.
module divider
    import mips_alu_pkg::*;
#(
    parameter int WIDTH = DIV_ITER
) (
    input  logic     clk,
    input  logic     reset,
    divider_if.slave bus
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e         state_q, state_d;
    logic [WIDTH:0]     rem_q, rem_d, step_rem;
    logic [WIDTH-1:0]   quot_q, quot_d, step_quot;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] ans_q, ans_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] result;

`ifdef DIVIDER_SIGNED_EN
    logic [WIDTH-1:0]   a_raw_q, a_raw_d;
    logic               a_neg_q, a_neg_d;
    logic               b_neg_q, b_neg_d;
    logic [WIDTH-1:0]   q_fix, r_fix;
`endif

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (divisor_q),
        .rem_o     (step_rem),
        .quot_o    (step_quot)
    );

    // Operand magnitudes fed to the unsigned core at capture time.
    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        a_mag = (bus.sgn && bus.A[WIDTH-1]) ? -bus.A : bus.A;
        b_mag = (bus.sgn && bus.B[WIDTH-1]) ? -bus.B : bus.B;
`else
        a_mag = bus.A;
        b_mag = bus.B;
`endif
    end

    always_comb begin
`ifdef DIVIDER_SIGNED_EN
        q_fix = (a_neg_q ^ b_neg_q) ? -quot_q : quot_q;
        r_fix = a_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        // A zero divisor reports the raw dividend, never a sign-corrected one.
        if (divisor_q == '0) begin
            result = {a_raw_q, {WIDTH{1'b1}}};
        end else begin
            result = {r_fix, q_fix};
        end
`else
        result = {rem_q[WIDTH-1:0], quot_q};
`endif
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.sel) state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next-state
    always_comb begin
        rem_d     = rem_q;
        quot_d    = quot_q;
        divisor_d = divisor_q;
        cnt_d     = cnt_q;
        ans_d     = ans_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dbz_d     = dbz_q;
`ifdef DIVIDER_SIGNED_EN
        a_raw_d   = a_raw_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.sel) begin
                    rem_d     = '0;
                    quot_d    = a_mag;
                    divisor_d = b_mag;
                    cnt_d     = '0;
                    busy_d    = 1'b1;
`ifdef DIVIDER_SIGNED_EN
                    a_raw_d   = bus.A;
                    a_neg_d   = bus.sgn & bus.A[WIDTH-1];
                    b_neg_d   = bus.sgn & bus.B[WIDTH-1];
`endif
                end
            end
            RUN: begin
                rem_d  = step_rem;
                quot_d = step_quot;
                cnt_d  = cnt_q + 1'b1;
            end
            DONE: begin
                ans_d  = result;
                dbz_d  = (divisor_q == '0);
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            ans_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            a_raw_q   <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
`endif
        end else begin
            rem_q     <= rem_d;
            quot_q    <= quot_d;
            divisor_q <= divisor_d;
            cnt_q     <= cnt_d;
            ans_q     <= ans_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
            a_raw_q   <= a_raw_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
`endif
        end
    end

    assign bus.DIVUAns     = ans_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;

endmodule

// File: doc/divider.md
Name: divider

Overview:
- Sequential unsigned 32-bit restoring divider (DIVU) for the MIPS-Lite execute stage; companion to the shift-add multiplier.
- Accepts a start strobe with dividend/divisor and iterates one quotient bit per clock.
- Returns {remainder, quotient} as a 64-bit HI/LO word, the same packing as the multiplier's 64-bit product.
- The HI/LO write-back logic consumes the result on the done pulse.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH; iteration count equals WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  reset (one clock; reset is asynchronous and active-low)
- A  input  WIDTH  dividend, sampled only on an accepted start
- B  input  WIDTH  divisor, sampled only on an accepted start
- sel  input  1  start strobe, level-sampled each edge
- DIVUAns  output  2*WIDTH  [63:32] remainder (HI), [31:0] quotient (LO)
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when DIVUAns is updated
- div_by_zero  output  1  flag for the last completed operation, valid with and after done

Behaviour:
- Reset (reset low, asynchronous) forces:
  - state IDLE;
  - DIVUAns = 0, busy = 0, done = 0, div_by_zero = 0;
  - internal remainder, quotient and counter = 0.
- Reset asserted mid-operation aborts the division. No done pulse follows.
- States:
  - IDLE: done = 0 except in the cycle right after completion. If sel = 1 at an edge, capture A and B, clear the 33-bit partial remainder, load quotient = A, counter = 0, go to RUN, busy = 1.
  - RUN: each edge performs one iteration:
    - shift {rem, quot} left by 1;
    - trial = rem - {0, B};
    - if trial is non-negative, rem = trial and quot[0] = 1; otherwise restore rem and set quot[0] = 0;
    - counter increments.
  - RUN exit: after the edge with counter == WIDTH-1, go to DONE.
  - DONE: one edge. Register DIVUAns = {rem[31:0], quot}, div_by_zero = (B == 0), done = 1, busy = 0, return to IDLE.
- Latency: sel sampled at edge E0; iterations at E1..E32; result and done at E33. busy is high from E0 through E33 (32+1 cycles).
- sel while busy is ignored. No queuing and no restart.
- sel in the cycle where done is high is accepted at the next edge, giving back-to-back operations at a 34-cycle period.
- DIVUAns holds its value until the next completion.
- Divide by zero needs no special path; the algorithm naturally yields quotient = all ones and remainder = dividend. div_by_zero = 1.
- Dividend < divisor gives quotient 0 and remainder = dividend.
- The subtractor is WIDTH+1 bits wide, so no overflow is possible.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN
- Defined: adds input port sgn (1 bit, sampled with sel).
  - If sgn = 1, operands are converted to magnitudes at capture. The divider core is unchanged.
  - In DONE, the quotient is negated if the operand signs differ, and the remainder takes the sign of the dividend.
  - -2^31 / -1 gives quotient 0x80000000, remainder 0.
  - Divide by zero gives quotient 0xFFFFFFFF and remainder = A (raw, not negated), with div_by_zero = 1.
- Undefined: port is absent; all operations are unsigned.

Decomposition:
- Shared package (mips_alu_pkg):
  - state enum IDLE/RUN/DONE;
  - DIV_ITER = WIDTH constant;
  - HI/LO field index constants shared with the multiplier.
- Sub-module divider_step: combinational single iteration.
  - Inputs: rem, quot, divisor.
  - Outputs: next rem, next quot.
  - Reusable for an unrolled variant.

Test Plan:
- A=100, B=7, sel pulse: busy for 33 cycles, done at E33, DIVUAns = 64'h00000002_0000000E, div_by_zero = 0.
- A=32'hFFFFFFFF, B=1: DIVUAns = 64'h00000000_FFFFFFFF. Then A=3, B=10 issued in the done cycle: next result 64'h00000003_00000000 at 34 cycles later.
- A=5, B=0: DIVUAns = 64'h00000005_FFFFFFFF, div_by_zero = 1.
- Start A=100, B=7, then sel held high with A=9, B=3 during RUN: result still 64'h00000002_0000000E; second operation starts only after done.
- Reset low at E10 of a run: all outputs 0 immediately (asynchronously); no done pulse; fresh start then completes correctly.
- (DIVIDER_SIGNED_EN) sgn=1, A=-7, B=2: DIVUAns = 64'hFFFFFFFF_FFFFFFFD. A=32'h80000000, B=-1: 64'h00000000_80000000.
